// File: rtl/adc_pkg.sv
// Shared types and frame constants for the ADC128S022-style SPI sampler.
// The state enum, the frame geometry and the address-bit helper are used by the top and the ticker.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } adc_state_t;

  localparam int ADC_FRAME_BITS   = 16;
  localparam int ADC_LEAD_ZEROS   = 4;
  localparam int ADC_DATA_W       = 12;
  localparam int ADC_ADDR_MSB_POS = 2;
  localparam int ADC_HALF_PERIODS = 2 * ADC_FRAME_BITS;

  // Address word bit for frame position bit_pos: channel MSB..LSB sit at positions 2..4.
  function automatic logic addr_bit(input logic [2:0] chan, input logic [3:0] bit_pos);
    logic b;
    int   pos;
    b   = 1'b0;
    pos = int'(bit_pos);
    if (pos >= ADC_ADDR_MSB_POS && pos <= ADC_ADDR_MSB_POS + 2)
      b = chan[2'(ADC_ADDR_MSB_POS + 2 - pos)];
    return b;
  endfunction

endpackage

// File: rtl/half_period_ticker.sv
// Divides sysclk into SCLK half-periods and counts half-periods within the SHIFT phase.
// The FSM clears both counters when it accepts a new request.
module half_period_ticker
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       run,
  input  logic       shift_en,
  output logic       tick,
  output logic [4:0] half_idx
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;

  assign tick = run && (div_cnt == TERM);

  // div_cnt stays at zero while idle so every phase starts with a full CLK_DIV window.
  always_ff @(posedge sysclk) begin
    if (!rst_n || restart) begin
      div_cnt  <= '0;
      half_idx <= '0;
    end else if (run) begin
      if (tick) begin
        div_cnt <= '0;
        if (shift_en)
          half_idx <= half_idx + 5'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master for a 12-bit, 8-channel serial ADC with 16-SCLK frames.
// One conversion per request, or back-to-back frames while continuous is held high.
module adc_spi_sampler
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [2:0]  channel,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] data_ad,
  output logic        valid,
  output logic        busy
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("adc_spi_sampler: CLK_DIV must be within 2..255");
  end

  if (ADC_LEAD_ZEROS + ADC_DATA_W != ADC_FRAME_BITS) begin : g_bad_frame
    $error("adc_spi_sampler: frame geometry is inconsistent");
  end

  adc_state_t                  state, state_d;
  logic                        cs_n_d, sclk_d, din_d, valid_d, busy_d;
  logic [ADC_DATA_W-1:0]       data_d;
  logic [ADC_FRAME_BITS-1:0]   shift_q, shift_d;
  logic [2:0]                  chan_q, chan_d;
  logic                        accept, want;
  logic                        tick;
  logic [4:0]                  half_idx, next_half;

  half_period_ticker #(
    .CLK_DIV(CLK_DIV)
  ) u_ticker (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .restart (accept),
    .run     (state != IDLE),
    .shift_en(state == SHIFT),
    .tick    (tick),
    .half_idx(half_idx)
  );

  assign want      = start || continuous;
  assign next_half = half_idx + 5'd1;

  // The end of QUIET doubles as an accept point so continuous frames repeat every 34 half-periods.
  always_comb begin
    state_d = state;
    cs_n_d  = adc_cs_n;
    sclk_d  = adc_sclk;
    din_d   = adc_din;
    data_d  = data_ad;
    valid_d = 1'b0;
    busy_d  = busy;
    shift_d = shift_q;
    chan_d  = chan_q;
    accept  = 1'b0;

    case (state)
      IDLE: begin
        if (want)
          accept = 1'b1;
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          din_d   = addr_bit(chan_q, 4'd0);
        end
      end
      SHIFT: begin
        if (tick) begin
          if (half_idx == 5'(ADC_HALF_PERIODS - 1)) begin
            state_d = QUIET;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            din_d   = 1'b0;
            data_d  = shift_q[ADC_DATA_W-1:0];
            valid_d = 1'b1;
          end else if (!next_half[0]) begin
            sclk_d = 1'b0;
            din_d  = addr_bit(chan_q, next_half[4:1]);
          end else begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[ADC_FRAME_BITS-2:0], adc_dout};
          end
        end
      end
      QUIET: begin
        if (tick) begin
          if (want) begin
            accept = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = SETUP;
      cs_n_d  = 1'b0;
      sclk_d  = 1'b1;
      din_d   = 1'b0;
      busy_d  = 1'b1;
      chan_d  = channel;
    end
  end

  // All pins are registered; reset abandons any partial frame without a strobe.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      adc_din  <= 1'b0;
      data_ad  <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      shift_q  <= '0;
      chan_q   <= '0;
    end else begin
      state    <= state_d;
      adc_cs_n <= cs_n_d;
      adc_sclk <= sclk_d;
      adc_din  <= din_d;
      data_ad  <= data_d;
      valid    <= valid_d;
      busy     <= busy_d;
      shift_q  <= shift_d;
      chan_q   <= chan_d;
    end
  end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

- Upstream capture stage for the UART reader path.
- Drives a 12-bit, 8-channel serial ADC (ADC128S022-style, 16-SCLK frame) over SPI and returns one conversion per request.
- Presents the result on `data_ad` with a one-cycle `valid` strobe; this is the bus the reader serialises onto `tx`.
- Supports single-shot requests and free-running continuous sampling.

## Interface
- `CLK_DIV`, default 25: `sysclk` cycles per SCLK half-period (50 MHz gives 1 MHz SCLK). Legal range is 2..255; elaboration fails outside it.
- `sysclk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  conversion request; sampled only in IDLE
- `continuous`  in  1  when 1, re-arm automatically after each frame
- `channel`  in  3  ADC input select; latched when a request is accepted
- `adc_dout`  in  1  serial data from the ADC
- `adc_cs_n`  out  1  chip select, active-low, registered
- `adc_sclk`  out  1  serial clock, idles high, registered
- `adc_din`  out  1  serial address to the ADC, registered
- `data_ad`  out  12  last completed sample; holds until the next frame completes
- `valid`  out  1  one-cycle strobe when `data_ad` updates
- `busy`  out  1  high from request acceptance until return to IDLE

## Operation
- **States:** IDLE → SETUP → SHIFT → QUIET → IDLE.
- **IDLE:**
  - On an edge with `start`=1 or `continuous`=1, latch `channel` and enter SETUP.
  - On the same edge, drive `adc_cs_n`=0 and `busy`=1.
- **SETUP:** one half-period (`CLK_DIV` cycles) with `adc_sclk`=1 and `adc_cs_n`=0.
- **SHIFT:** 32 half-periods, i.e. 16 SCLK cycles. Frame bits are indexed 0..15.
  - At the start of each even half-period, `adc_sclk` falls. On that same edge, `adc_din` is driven with frame bit n of the address word: bits 2, 3, 4 carry `channel[2]`, `channel[1]`, `channel[0]`; all other bits are 0.
  - At the start of each odd half-period, `adc_sclk` rises. On that same edge, `adc_dout` is shifted into a 16-bit register, MSB first.
  - Frame bits 0..3 are leading zeros and are discarded. Bits 4..15 are D11..D0.
- **Frame end:** at the end of the 32nd half-period, `adc_cs_n` goes to 1, `adc_sclk` stays 1, and `data_ad` is loaded from shift[11:0]. `valid`=1 for exactly that one cycle. Enter QUIET.
- **QUIET:** `CLK_DIV` cycles with `adc_cs_n`=1, which guarantees ADC CS-high time. Then IDLE with `busy`=0.
  - If `continuous`=1, IDLE re-accepts on its first cycle.
- **Requests:** `start` asserted outside IDLE is ignored; it is not queued.
- **Channel changes:** `channel` changes after acceptance have no effect on the current frame.
- **Reset:** `rst_n`=0 at any edge, including mid-frame, forces on the next edge:
  - state IDLE, `adc_cs_n`=1, `adc_sclk`=1, `adc_din`=0;
  - `data_ad`=12'h000, `valid`=0, `busy`=0;
  - shift register and counters cleared.
  - A partial frame is discarded; no `valid` is produced.

## Timing
- **Reference edge:** the request-accepting edge is edge 0. `adc_cs_n` falls and `busy` rises in the cycle following edge 0.
- **First SCLK fall:** edge `CLK_DIV`.
- **k-th SCLK rise (k=1..16):** edge `CLK_DIV`·2k. `adc_dout` is sampled on this edge.
- **Frame completion:** `valid`, `data_ad` update and `adc_cs_n` rise all occur at edge 33·`CLK_DIV`.
- **Return to IDLE:** `busy` falls at edge 34·`CLK_DIV`. The earliest next accept is that same edge, so the continuous-mode period is 34·`CLK_DIV` cycles.
- **Combinational paths:** no input-to-output combinational path exists.

## Structure
- Shared package `adc_pkg` holds:
  - the state enum (IDLE, SETUP, SHIFT, QUIET);
  - `ADC_FRAME_BITS`=16, `ADC_LEAD_ZEROS`=4, `ADC_DATA_W`=12;
  - `ADC_ADDR_MSB_POS`=2.
- Sub-module `half_period_ticker`: a counter of `CLK_DIV` cycles that emits a one-cycle tick and clears on `rst_n` or on an FSM restart. It also counts half-periods within SHIFT (0..31) for the FSM.

## Test plan
- **Single shot:** `CLK_DIV`=4, `channel`=3, ADC model returns 12'h5F3, pulse `start` → `adc_din` reads 0,0,0,1,1,0… in bits 0..5; `valid` fires once at edge 132 with `data_ad`=12'h5F3; `busy` falls at edge 136.
- **Start during busy:** second `start` pulse at edge 50 → ignored; exactly one `valid`; `data_ad` unchanged afterwards.
- **Continuous mode:** `continuous`=1, model returns 12'h001, 12'hFFF, 12'h800 → three `valid` strobes spaced exactly 136 cycles apart, carrying those values in order.
- **Mid-frame channel change:** `channel` switches from 7 to 0 at edge 40 → the frame's address bits stay 1,1,1.
- **Reset mid-frame:** `rst_n` low at edge 70 for 2 cycles → `adc_cs_n`=1, `adc_sclk`=1, `busy`=0, `data_ad`=0, no `valid`; a subsequent `start` completes normally.
- **Leading-bit masking:** model drives 1 on frame bits 0..3 and data 12'h0A5 → `data_ad`=12'h0A5.
